// File: rtl/uart_prog_pkg.sv
// Shared definitions for the UART program loader: FSM encodings, the default
// start word and the elaboration-time helpers for bit timing and address width.
// Optional feature macro: PROG_CHECKSUM_EN adds the CSUM state.
package uart_prog_pkg;

`ifdef PROG_CHECKSUM_EN
  typedef enum logic [2:0] {ST_IDLE, ST_LEN, ST_DATA, ST_CSUM, ST_DONE} state_t;
`else
  typedef enum logic [2:0] {ST_IDLE, ST_LEN, ST_DATA, ST_DONE} state_t;
`endif

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_BITS, RX_STOP} rx_state_t;

  // "TEKN" received as the byte stream 54 45 4B 4E
  localparam logic [31:0] DEFAULT_MAGIC = 32'h4E4B4554;

  function automatic int clog2(input longint unsigned value);
    int bits;
    longint unsigned span;
    bits = 0;
    span = 1;
    while (span < value) begin
      span = span << 1;
      bits++;
    end
    return bits;
  endfunction

  function automatic int clks_per_bit(input int clk_freq_hz, input int baud_rate);
    return clk_freq_hz / baud_rate;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// UART byte receiver: 2-flop synchronizer, start-bit qualification at half a
// bit, mid-bit sampling of 8 data bits (LSB first) and stop-bit check.
// rx_valid / frame_err are single-cycle pulses at the stop-bit sample.
module uart_rx_byte
  import uart_prog_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       frame_err
);

  localparam int CNT_W = clog2(CLKS_PER_BIT) + 1;
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  logic             sync1, sync2, line_prev;
  logic             fall, half_tick, bit_tick;
  rx_state_t        state, state_n;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;

  assign fall      = line_prev & ~sync2;
  assign half_tick = (cnt == HALF_LAST);
  assign bit_tick  = (cnt == BIT_LAST);
  assign rx_data   = shreg;

  // Synchronize the asynchronous line; the third flop gives edge detection
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1     <= 1'b1;
      sync2     <= 1'b1;
      line_prev <= 1'b1;
    end else begin
      sync1     <= rx;
      sync2     <= sync1;
      line_prev <= sync2;
    end
  end

  // Receiver state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= RX_IDLE;
    else        state <= state_n;
  end

  // Receiver next state: a start bit that is gone by half a bit was a glitch
  always_comb begin
    state_n = state;
    unique case (state)
      RX_IDLE:  if (fall) state_n = RX_START;
      RX_START: if (half_tick) state_n = sync2 ? RX_IDLE : RX_BITS;
      RX_BITS:  if (bit_tick && (bit_idx == 3'd7)) state_n = RX_STOP;
      RX_STOP:  if (bit_tick) state_n = RX_IDLE;
      default:  state_n = RX_IDLE;
    endcase
  end

  // Byte strobes at the stop-bit sample; a low stop bit drops the byte
  always_comb begin
    rx_valid  = (state == RX_STOP) && bit_tick && sync2;
    frame_err = (state == RX_STOP) && bit_tick && !sync2;
  end

  // Bit timer restarts at the start-bit midpoint so later samples land mid-bit
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt     <= '0;
      bit_idx <= '0;
    end else begin
      if ((state == RX_IDLE) || ((state == RX_START) && half_tick) || bit_tick)
        cnt <= '0;
      else
        cnt <= cnt + CNT_W'(1);
      if (state == RX_START)
        bit_idx <= '0;
      else if ((state == RX_BITS) && bit_tick)
        bit_idx <= bit_idx + 3'd1;
    end
  end

  // Deserializer, LSB first
  always_ff @(posedge clk) begin
    if ((state == RX_BITS) && bit_tick) shreg <= {sync2, shreg[7:1]};
  end

endmodule

// File: rtl/uart_prog_loader.sv
// UART boot loader: waits for the MAGIC word, reads a little-endian word
// count, then writes that many little-endian words into program RAM while
// holding the processor subsystem in reset.
// Optional feature macro: PROG_CHECKSUM_EN (trailing XOR checksum byte).
module uart_prog_loader
  import uart_prog_pkg::*;
#(
  parameter int          CLK_FREQ_HZ    = 100000000,
  parameter int          BAUD_RATE      = 115200,
  parameter int          RAM_DEPTH      = 131072,
  parameter logic [31:0] MAGIC          = DEFAULT_MAGIC,
  parameter int          TIMEOUT_CYCLES = 100000000,
  parameter int          RESET_HOLD     = 16,
  localparam int         ADDR_W         = clog2(RAM_DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              prog_rx_i,
  output logic              prog_mode_o,
  output logic              system_reset_no,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  output logic              prog_err_o
);

  localparam int              CLKS_PER_BIT = clks_per_bit(CLK_FREQ_HZ, BAUD_RATE);
  localparam int              WC_W         = ADDR_W + 1;
  localparam logic [31:0]     DEPTH_W32    = 32'(RAM_DEPTH);
  localparam logic [31:0]     TIMEOUT_W32  = 32'(TIMEOUT_CYCLES);
  localparam logic [31:0]     HOLD_LAST    = 32'(RESET_HOLD - 1);
  localparam logic [WC_W-1:0] ONE_WORD     = WC_W'(1);
`ifdef PROG_CHECKSUM_EN
  localparam state_t          ST_PAYLOAD_END = ST_CSUM;
`else
  localparam state_t          ST_PAYLOAD_END = ST_DONE;
`endif

  state_t            state, state_n;
  logic              rx_valid, frame_err;
  logic [7:0]        rx_data;
  logic [31:0]       sr, sr_next, word, word_next;
  logic [1:0]        byte_cnt;
  logic [WC_W-1:0]   n_words;
  logic [ADDR_W-1:0] idx;
  logic [31:0]       tmo_cnt, hold_cnt;
  logic              payload_byte, byte_last, timed_state;
  logic              magic_hit, len_done, len_big, len_zero;
  logic              word_done, last_word, tmo_hit, hold_done;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk      (clk_i),
    .rst_n    (rst_ni),
    .rx       (prog_rx_i),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .frame_err(frame_err)
  );

  assign sr_next      = {rx_data, sr[31:8]};
  assign word_next    = {rx_data, word[31:8]};
  assign payload_byte = rx_valid && ((state == ST_LEN) || (state == ST_DATA));
  assign byte_last    = rx_valid && (byte_cnt == 2'd3);
  assign timed_state  = (state != ST_IDLE) && (state != ST_DONE);
  assign magic_hit    = (state == ST_IDLE) && rx_valid && (sr_next == MAGIC);
  assign len_done     = (state == ST_LEN) && byte_last;
  assign len_big      = (word_next > DEPTH_W32);
  assign len_zero     = (word_next == 32'd0);
  assign word_done    = (state == ST_DATA) && byte_last;
  assign last_word    = ({1'b0, idx} == (n_words - ONE_WORD));
  assign tmo_hit      = timed_state && !rx_valid && (tmo_cnt == TIMEOUT_W32);
  assign hold_done    = (hold_cnt == HOLD_LAST);

`ifdef PROG_CHECKSUM_EN
  logic [7:0] csum;
  logic       csum_bad;
  assign csum_bad = (state == ST_CSUM) && rx_valid && (rx_data != csum);

  // Running XOR over every length and payload byte of the current frame
  always_ff @(posedge clk_i) begin
    if (magic_hit)         csum <= '0;
    else if (payload_byte) csum <= csum ^ rx_data;
  end
`endif

  // Loader state register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) state <= ST_IDLE;
    else         state <= state_n;
  end

  // Loader next state; a timeout abandons the frame from any receiving state
  always_comb begin
    state_n = state;
    unique case (state)
      ST_IDLE: if (magic_hit) state_n = ST_LEN;
      ST_LEN: begin
        if (tmo_hit) state_n = ST_IDLE;
        else if (len_done) begin
          if (len_big)       state_n = ST_IDLE;
          else if (len_zero) state_n = ST_PAYLOAD_END;
          else               state_n = ST_DATA;
        end
      end
      ST_DATA: begin
        if (tmo_hit)                       state_n = ST_IDLE;
        else if (word_done && last_word)   state_n = ST_PAYLOAD_END;
      end
`ifdef PROG_CHECKSUM_EN
      ST_CSUM: begin
        if (tmo_hit)       state_n = ST_IDLE;
        else if (rx_valid) state_n = ST_DONE;
      end
`endif
      ST_DONE: if (hold_done) state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // LED and subsystem reset follow the state, so they flip on the same edge
  always_comb begin
    prog_mode_o     = (state != ST_IDLE);
    system_reset_no = (state == ST_IDLE);
  end

  // Little-endian assembly of length and payload words
  always_ff @(posedge clk_i) begin
    if (payload_byte) word <= word_next;
  end

  // Control counters, MAGIC window, RAM write port and sticky error flag
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sr          <= '0;
      byte_cnt    <= '0;
      n_words     <= '0;
      idx         <= '0;
      tmo_cnt     <= '0;
      hold_cnt    <= '0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      prog_err_o  <= 1'b0;
    end else begin
      mem_we_o <= 1'b0;
      tmo_cnt  <= (timed_state && !rx_valid) ? tmo_cnt + 32'd1 : 32'd0;
      hold_cnt <= (state == ST_DONE) ? hold_cnt + 32'd1 : 32'd0;
      // A lost byte breaks the contiguous window, so matching restarts
      if (state == ST_IDLE) begin
        if (magic_hit || frame_err) sr <= '0;
        else if (rx_valid)          sr <= sr_next;
      end
      if (magic_hit) begin
        byte_cnt   <= '0;
        prog_err_o <= 1'b0;
      end else if (payload_byte) begin
        byte_cnt <= byte_cnt + 2'd1;
      end
      if (len_done) begin
        n_words <= word_next[ADDR_W:0];
        idx     <= '0;
        if (len_big) prog_err_o <= 1'b1;
      end
      if (word_done) begin
        mem_we_o    <= 1'b1;
        mem_addr_o  <= idx;
        mem_wdata_o <= word_next;
        idx         <= idx + ADDR_W'(1);
      end
      if (tmo_hit) prog_err_o <= 1'b1;
`ifdef PROG_CHECKSUM_EN
      if (csum_bad) prog_err_o <= 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_uart_prog_loader.sv
// Scoreboard bench for uart_prog_loader at 10 clocks per UART bit.
module tb_uart_prog_loader;
  import uart_prog_pkg::*;

  localparam int ADDR_W   = 6;
  localparam int BIT_CLKS = 10;

  logic              clk = 1'b0;
  logic              rst_ni = 1'b0;
  logic              prog_rx_i = 1'b1;
  logic              prog_mode_o, system_reset_no, mem_we_o, prog_err_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [31:0]       mem_wdata_o;

  int          n_checks = 0;
  int          n_pass = 0;
  logic [37:0] exp_q[$];
  int          cyc = 0;
  int          last_we_cyc = 0;
  int          rst_rises = 0;
  int          rise_rel = -1;
  int          rises_before = 0;
  logic        prev_rst = 1'b1;

  uart_prog_loader #(
    .CLK_FREQ_HZ   (1000000),
    .BAUD_RATE     (100000),
    .RAM_DEPTH     (64),
    .MAGIC         (32'h4E4B4554),
    .TIMEOUT_CYCLES(2000),
    .RESET_HOLD    (16)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .prog_rx_i      (prog_rx_i),
    .prog_mode_o    (prog_mode_o),
    .system_reset_no(system_reset_no),
    .mem_we_o       (mem_we_o),
    .mem_addr_o     (mem_addr_o),
    .mem_wdata_o    (mem_wdata_o),
    .prog_err_o     (prog_err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    else n_pass++;
  endtask

  function automatic logic [37:0] wr(input logic [5:0] addr, input logic [31:0] data);
    return {addr, data};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit = 1'b1);
    prog_rx_i = 1'b0;
    tick(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      prog_rx_i = b[i];
      tick(BIT_CLKS);
    end
    prog_rx_i = stop_bit;
    tick(BIT_CLKS);
    prog_rx_i = 1'b1;
    tick(BIT_CLKS);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic send_magic();
    send_word(32'h4E4B4554);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_mode"},  64'(prog_mode_o),     64'd0);
    check({tag, "_sysrst"}, 64'(system_reset_no), 64'd1);
    check({tag, "_we"},    64'(mem_we_o),        64'd0);
    check({tag, "_addr"},  64'(mem_addr_o),      64'd0);
    check({tag, "_wdata"}, 64'(mem_wdata_o),     64'd0);
    check({tag, "_err"},   64'(prog_err_o),      64'd0);
  endtask

  // Monitor: every write strobe is popped against the scoreboard
  initial begin
    logic [37:0] e;
    forever begin
      @(negedge clk);
      cyc++;
      if (mem_we_o === 1'b1) begin
        last_we_cyc = cyc;
        if (exp_q.size() == 0) begin
          check("unexpected_write", 64'(mem_we_o), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("write_addr", 64'(mem_addr_o), 64'(e[37:32]));
          check("write_data", 64'(mem_wdata_o), 64'(e[31:0]));
        end
      end
      if (prev_rst === 1'b0 && system_reset_no === 1'b1) begin
        rst_rises++;
        rise_rel = cyc - last_we_cyc;
      end
      prev_rst = system_reset_no;
    end
  end

  initial begin
    tick(4);
    rst_ni = 1'b1;
    tick(2);
    check_reset_values("reset");

    // Happy path
    send_magic();
    check("happy_mode_on", 64'(prog_mode_o), 64'd1);
    check("happy_sysrst_low", 64'(system_reset_no), 64'd0);
    rises_before = rst_rises;
    exp_q.push_back(wr(6'd0, 32'h44332211));
    exp_q.push_back(wr(6'd1, 32'hDDCCBBAA));
    send_word(32'd2);
    send_word(32'h44332211);
    send_word(32'hDDCCBBAA);
`ifdef PROG_CHECKSUM_EN
    send_byte(8'h00);
    tick(40);
    check("csum_bad_err", 64'(prog_err_o), 64'd1);
    check("csum_bad_sysrst", 64'(system_reset_no), 64'd1);
    check("csum_bad_rises", 64'(rst_rises), 64'(rises_before + 1));
    send_magic();
    check("csum_err_cleared", 64'(prog_err_o), 64'd0);
    exp_q.push_back(wr(6'd0, 32'h44332211));
    exp_q.push_back(wr(6'd1, 32'hDDCCBBAA));
    send_word(32'd2);
    send_word(32'h44332211);
    send_word(32'hDDCCBBAA);
    send_byte(8'h46);
    tick(40);
    check("csum_good_err", 64'(prog_err_o), 64'd0);
    check("csum_good_sysrst", 64'(system_reset_no), 64'd1);
`else
    tick(40);
    check("happy_err", 64'(prog_err_o), 64'd0);
    check("happy_mode_off", 64'(prog_mode_o), 64'd0);
    check("happy_sysrst_high", 64'(system_reset_no), 64'd1);
    check("happy_one_release", 64'(rst_rises), 64'(rises_before + 1));
    check("happy_hold_cycles", 64'(rise_rel), 64'd16);
`endif
    check("happy_writes_done", 64'(exp_q.size()), 64'd0);

    // Oversize length: 65 words into a 64-word RAM
    send_magic();
    send_word(32'd65);
    check("oversize_err", 64'(prog_err_o), 64'd1);
    check("oversize_mode", 64'(prog_mode_o), 64'd0);
    check("oversize_sysrst", 64'(system_reset_no), 64'd1);

    // Timeout after a partial word
    send_magic();
    check("timeout_err_cleared", 64'(prog_err_o), 64'd0);
    send_word(32'd1);
    send_byte(8'h11);
    send_byte(8'h22);
    tick(1900);
    check("timeout_not_yet", 64'(prog_mode_o), 64'd1);
    tick(200);
    check("timeout_err", 64'(prog_err_o), 64'd1);
    check("timeout_mode", 64'(prog_mode_o), 64'd0);
    check("timeout_sysrst", 64'(system_reset_no), 64'd1);

    // Framing error on a garbage byte and a short glitch inside MAGIC
    send_byte(8'hA5, 1'b0);
    send_byte(8'h00);
    send_byte(8'h54);
    send_byte(8'h45);
    prog_rx_i = 1'b0;
    tick(3);
    prog_rx_i = 1'b1;
    tick(30);
    check("noise_no_early_magic", 64'(prog_mode_o), 64'd0);
    send_byte(8'h4B);
    send_byte(8'h4E);
    check("noise_magic_found", 64'(prog_mode_o), 64'd1);
    check("noise_err_cleared", 64'(prog_err_o), 64'd0);
    send_word(32'd0);
`ifdef PROG_CHECKSUM_EN
    send_byte(8'h00);
`endif
    tick(40);
    check("zero_len_mode", 64'(prog_mode_o), 64'd0);
    check("zero_len_sysrst", 64'(system_reset_no), 64'd1);
    check("zero_len_err", 64'(prog_err_o), 64'd0);

    // Reset in the middle of DATA, then a fresh frame
    send_magic();
    exp_q.push_back(wr(6'd0, 32'h44332211));
    exp_q.push_back(wr(6'd1, 32'hDDCCBBAA));
    send_word(32'd3);
    send_word(32'h44332211);
    send_word(32'hDDCCBBAA);
    send_byte(8'h55);
    check("midframe_in_data", 64'(prog_mode_o), 64'd1);
    rst_ni = 1'b0;
    tick(1);
    check_reset_values("midreset");
    rst_ni = 1'b1;
    tick(2);
    send_magic();
    exp_q.push_back(wr(6'd0, 32'h04030201));
    send_word(32'd1);
    send_word(32'h04030201);
`ifdef PROG_CHECKSUM_EN
    send_byte(8'h05);
`endif
    tick(40);
    check("fresh_err", 64'(prog_err_o), 64'd0);
    check("fresh_mode", 64'(prog_mode_o), 64'd0);
    check("fresh_sysrst", 64'(system_reset_no), 64'd1);
    check("all_writes_seen", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
